// File: rtl/fuse_key_loader_if.sv
// Fuse memory read port: request, word address and read data.
// The read data is valid the cycle after the request is presented.
//   master : driven by the key loader (req, addr out; rdata in)
//   slave  : fuse memory side       (req, addr in;  rdata out)
interface fuse_key_loader_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rdata
  );
endinterface

// File: rtl/fuse_key_loader.sv
// Fuse key loader: on a start command, reads a contiguous run of 32-bit
// fuse words (one request per cycle, one-cycle read latency) and assembles
// them into a key shadow register presented with a valid flag.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        load command, sampled only in IDLE
//   base_i         fuse word address of the first word
//   nwords_i       word count, valid range 1..NUM_WORDS
//   clear_i        zeroise key and abort any load (highest priority)
//   fuse           fuse memory read port (master side)
//   key_o          assembled key; word i (address base+i) at bits [32*i +: 32]
//   key_valid_o    key complete and stable
//   busy_o         load in progress
//   err_o          one-cycle pulse on a rejected command
module fuse_key_loader #(
  parameter int NUM_WORDS = 8,
  parameter int MEM_SIZE  = 100
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [31:0]              base_i,
  input  logic [3:0]               nwords_i,
  input  logic                     clear_i,
  fuse_key_loader_if.master        fuse,
  output logic [32*NUM_WORDS-1:0]  key_o,
  output logic                     key_valid_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int KW = 32 * NUM_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  state_e          state_q,   state_d;
  logic [31:0]     base_q,    base_d;
  logic [3:0]      n_q,       n_d;
  logic [3:0]      rd_cnt_q,  rd_cnt_d;
  logic            req_q,     req_d;
  logic [31:0]     addr_q,    addr_d;
  logic [3:0]      req_idx_q, req_idx_d;
  logic            cap_vld_q, cap_vld_d;
  logic [3:0]      cap_idx_q, cap_idx_d;
  logic [KW-1:0]   key_q,     key_d;
  logic            valid_q,   valid_d;
  logic            busy_q,    busy_d;
  logic            err_q,     err_d;

  // Command check: address of the last word computed in 33 bits so a base
  // near the top of the 32-bit space cannot wrap into range.
  logic [32:0]     last_addr;
  logic            cmd_bad;

  always_comb begin
    last_addr = {1'b0, base_i} + 33'(nwords_i) - 33'd1;
    cmd_bad   = (nwords_i == 4'd0)
             || (32'(nwords_i) > 32'(NUM_WORDS))
             || (last_addr >= 33'(MEM_SIZE));
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    n_d       = n_q;
    rd_cnt_d  = rd_cnt_q;
    req_d     = 1'b0;
    addr_d    = addr_q;
    req_idx_d = req_idx_q;
    cap_vld_d = req_q;
    cap_idx_d = req_idx_q;
    key_d     = key_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    err_d     = 1'b0;

    // Read data for the request issued last cycle is on rdata now.
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      if (cap_vld_q && (32'(cap_idx_q) == w)) begin
        key_d[32*w +: 32] = fuse.rdata;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            base_d   = base_i;
            n_d      = nwords_i;
            rd_cnt_d = '0;
            key_d    = '0;
            valid_d  = 1'b0;
            busy_d   = 1'b1;
            state_d  = READ;
          end
        end
      end
      READ: begin
        req_d     = 1'b1;
        addr_d    = base_q + 32'(rd_cnt_q);
        req_idx_d = rd_cnt_q;
        rd_cnt_d  = rd_cnt_q + 4'd1;
        if (rd_cnt_q == n_q - 4'd1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear overrides everything, including a capture in flight and a
    // start presented in the same cycle.
    if (clear_i) begin
      state_d   = IDLE;
      rd_cnt_d  = '0;
      req_d     = 1'b0;
      cap_vld_d = 1'b0;
      key_d     = '0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      n_q       <= '0;
      rd_cnt_q  <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      req_idx_q <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      n_q       <= n_d;
      rd_cnt_q  <= rd_cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      req_idx_q <= req_idx_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign fuse.req    = req_q;
  assign fuse.addr   = addr_q;
  assign key_o       = key_q;
  assign key_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fuse_key_loader.sv
module tb_fuse_key_loader;

  localparam int KW = 256;

  logic           clk;
  logic           rst_i;
  logic           start_i;
  logic [31:0]    base_i;
  logic [3:0]     nwords_i;
  logic           clear_i;
  logic [KW-1:0]  key_o;
  logic           key_valid_o;
  logic           busy_o;
  logic           err_o;

  fuse_key_loader_if fif ();

  fuse_key_loader #(
    .NUM_WORDS (8),
    .MEM_SIZE  (100)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_i      (base_i),
    .nwords_i    (nwords_i),
    .clear_i     (clear_i),
    .fuse        (fif),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  // Fuse memory: one-cycle latency; garbage on cycles without a request.
  always @(posedge clk) begin
    if (fif.req) fif.rdata <= mem_word(fif.addr);
    else         fif.rdata <= $urandom;
  end

  int unsigned    vectors;
  int unsigned    miscompares;
  logic [KW-1:0]  exp_key;
  logic           exp_valid;

  task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit cmd_ok(input logic [31:0] b, input logic [3:0] n);
    longint unsigned last;
    last = longint'(b) + longint'(n) - 1;
    return (n >= 1) && (n <= 8) && (last < 100);
  endfunction

  // Issue one command and follow it cycle by cycle. Cycle 0 is the cycle
  // after the edge that samples start_i. Optional events at cycle k:
  // clear pulse, async reset between edges, or a start while busy.
  task automatic do_load(input logic [31:0] b, input logic [3:0] n,
                         input int clr_at, input int rst_at, input int poke_at);
    logic [KW-1:0] full;
    int nn;
    nn = int'(n);
    @(negedge clk);
    start_i = 1'b1; base_i = b; nwords_i = n;
    @(negedge clk);
    start_i = 1'b0;
    if (!cmd_ok(b, n)) begin
      check("rej_err",   err_o, 1'b1);
      check("rej_req",   fif.req, 1'b0);
      check("rej_busy",  busy_o, 1'b0);
      check("rej_key",   key_o, exp_key);
      check("rej_valid", key_valid_o, exp_valid);
      @(negedge clk);
      check("rej_err_end", err_o, 1'b0);
      check("rej_req1",    fif.req, 1'b0);
      check("rej_key1",    key_o, exp_key);
      return;
    end
    full = '0;
    for (int i = 0; i < nn; i++) full[32*i +: 32] = mem_word(b + 32'(i));
    exp_key = '0;
    exp_valid = 1'b0;
    check("acc_key_zero", key_o, '0);
    for (int k = 0; k <= nn + 2; k++) begin
      if (k > 0) begin
        @(negedge clk);
        start_i = 1'b0;
      end
      check("busy",  busy_o, (k <= nn + 1));
      check("valid", key_valid_o, (k == nn + 2));
      check("req",   fif.req, (k >= 1 && k <= nn));
      check("err",   err_o, 1'b0);
      if (k >= 1 && k <= nn) check("addr", fif.addr, b + 32'(k - 1));
      if (k == clr_at) begin
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("clr_busy",  busy_o, 1'b0);
        check("clr_req",   fif.req, 1'b0);
        check("clr_key",   key_o, '0);
        check("clr_valid", key_valid_o, 1'b0);
        @(negedge clk);
        check("clr_req2",  fif.req, 1'b0);
        check("clr_key2",  key_o, '0);
        exp_key = '0;
        exp_valid = 1'b0;
        return;
      end
      if (k == rst_at) begin
        #2 rst_i = 1'b1;
        #1;
        check("rst_key",   key_o, '0);
        check("rst_valid", key_valid_o, 1'b0);
        check("rst_busy",  busy_o, 1'b0);
        check("rst_err",   err_o, 1'b0);
        check("rst_req",   fif.req, 1'b0);
        check("rst_addr",  fif.addr, '0);
        @(negedge clk);
        rst_i = 1'b0;
        exp_key = '0;
        exp_valid = 1'b0;
        return;
      end
      if (k == poke_at) begin
        start_i  = 1'b1;
        base_i   = $urandom_range(0, 50);
        nwords_i = 4'd3;
      end
    end
    check("key", key_o, full);
    exp_key = full;
    exp_valid = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rb;
    logic [3:0]  rn;
    vectors = 0;
    miscompares = 0;
    exp_key = '0;
    exp_valid = 1'b0;
    rst_i = 1'b1;
    start_i = 1'b0;
    base_i = '0;
    nwords_i = '0;
    clear_i = 1'b0;
    #1;
    check("reset_key",   key_o, '0);
    check("reset_valid", key_valid_o, 1'b0);
    check("reset_busy",  busy_o, 1'b0);
    check("reset_err",   err_o, 1'b0);
    check("reset_req",   fif.req, 1'b0);
    check("reset_addr",  fif.addr, '0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    do_load(32'd10, 4'd8, -1, -1, -1);
    check("b10_lo", key_o[31:0], 32'hA500_000A);
    check("b10_hi", key_o[255:224], 32'hA500_0011);

    do_load(32'd99, 4'd1, -1, -1, -1);
    check("b99_lo", key_o[31:0], 32'hA500_0063);
    check("b99_hi", key_o[255:32], '0);

    do_load(32'd10, 4'd0, -1, -1, -1);
    do_load(32'd10, 4'd9, -1, -1, -1);
    do_load(32'd95, 4'd8, -1, -1, -1);
    do_load(32'hFFFF_FFFF, 4'd2, -1, -1, -1);
    check("rej_keep_valid", key_valid_o, 1'b1);

    do_load(32'd0, 4'd4, -1, -1, -1);
    do_load(32'd20, 4'd2, -1, -1, -1);
    check("b2b_key", key_o, {192'b0, 32'hA500_0015, 32'hA500_0014});

    do_load(32'd0, 4'd8, 4, -1, -1);
    do_load(32'd30, 4'd5, -1, -1, -1);

    do_load(32'd0, 4'd8, -1, 3, -1);
    do_load(32'd0, 4'd8, -1, -1, -1);

    do_load(32'd40, 4'd6, -1, -1, 2);

    // clear and start together: start dropped
    @(negedge clk);
    clear_i = 1'b1; start_i = 1'b1; base_i = 32'd0; nwords_i = 4'd2;
    @(negedge clk);
    clear_i = 1'b0; start_i = 1'b0;
    check("cs_valid", key_valid_o, 1'b0);
    check("cs_key",   key_o, '0);
    check("cs_busy",  busy_o, 1'b0);
    check("cs_err",   err_o, 1'b0);
    @(negedge clk);
    check("cs_req",   fif.req, 1'b0);
    check("cs_busy2", busy_o, 1'b0);
    exp_key = '0;
    exp_valid = 1'b0;

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin rb = $urandom_range(0, 99); rn = 4'($urandom_range(1, 8)); end
        1: begin rb = $urandom_range(0, 110); rn = 4'($urandom_range(0, 15)); end
        2: begin rb = $urandom; rn = 4'($urandom_range(1, 8)); end
        default: begin
          rn = 4'($urandom_range(1, 8));
          rb = 32'd100 - 32'(rn) + 32'($urandom_range(0, 1));
        end
      endcase
      do_load(rb, rn, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
